// File: rtl/viterbi_pkg.sv
// Shared trellis constants, the state-index type and branch-symbol helpers for
// the rate-1/2, K=3 (7,5) Viterbi decoder.
package viterbi_pkg;

  localparam int K       = 3;
  localparam int NSTATES = 4;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // State index is the encoder shift register {r1, r0}.
  typedef logic [K-2:0] state_t;

  // Symbol the encoder emits when input b arrives in state s: {g0 bit, g1 bit}.
  function automatic logic [1:0] branch_symbol(state_t s, logic b);
    logic [K-1:0] taps;
    taps = {b, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  // Hamming distance between two 2-bit symbols, 0..2.
  function automatic logic [1:0] hamming2(logic [1:0] a, logic [1:0] c);
    logic [1:0] x;
    x = a ^ c;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one next state: two saturating candidate metrics,
// keep the smaller, prefer the r0=0 predecessor (pm0) on a tie.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int MW = 8
) (
  input  logic [MW-1:0] pm0,
  input  logic [MW-1:0] pm1,
  input  logic [1:0]    bm0,
  input  logic [1:0]    bm1,
  output logic [MW-1:0] pm_out,
  output logic          sel
);

  logic [MW:0]   sum0;
  logic [MW:0]   sum1;
  logic [MW-1:0] cand0;
  logic [MW-1:0] cand1;

  // Saturating adds followed by the compare/select.
  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the unassigned value.
  always_comb begin
    sum0   = {1'b0, pm0} + {{(MW-1){1'b0}}, bm0};
    sum1   = {1'b0, pm1} + {{(MW-1){1'b0}}, bm1};
    cand0  = sum0[MW] ? '1 : sum0[MW-1:0];
    cand1  = sum1[MW] ? '1 : sum1[MW-1:0];
    sel    = (cand1 < cand0);
    pm_out = sel ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=3 (7,5) code: four ACS units,
// metric normalisation, register-exchange survivors and best-state output.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int D  = 16,
  parameter int MW = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic [1:0] d_in,
  output logic       valid_o,
  output logic       d_out
);

  localparam int            CW      = $clog2(D + 1);
  localparam logic [MW-1:0] PM_INIT = MW'(32);

  logic [MW-1:0]      pm_q     [NSTATES];
  logic [D-1:0]       surv_q   [NSTATES];
  logic [CW-1:0]      fill_q;

  logic [MW-1:0]      acs_pm   [NSTATES];
  logic [NSTATES-1:0] acs_sel;
  logic [MW-1:0]      pm_norm  [NSTATES];
  logic [D-1:0]       surv_new [NSTATES];
  logic [MW-1:0]      min_pm;
  state_t             best;

  // One ACS per next state ns={b,r1}; predecessors are {r1,0} and {r1,1}.
  for (genvar ns = 0; ns < NSTATES; ns++) begin : g_acs
    localparam state_t NS = state_t'(ns);
    localparam state_t P0 = {NS[0], 1'b0};
    localparam state_t P1 = {NS[0], 1'b1};

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = hamming2(d_in, branch_symbol(P0, NS[1]));
    assign bm1 = hamming2(d_in, branch_symbol(P1, NS[1]));

    viterbi_acs #(.MW(MW)) u_acs (
      .pm0    (pm_q[P0]),
      .pm1    (pm_q[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_out (acs_pm[ns]),
      .sel    (acs_sel[ns])
    );
  end

  // Find the best new metric (lowest index wins ties), normalise, and
  // extend each survivor from its selected predecessor.
  always_comb begin
    min_pm = acs_pm[0];
    best   = '0;
    for (int s = 1; s < NSTATES; s++) begin
      if (acs_pm[s] < min_pm) begin
        min_pm = acs_pm[s];
        best   = state_t'(s);
      end
    end
    for (int s = 0; s < NSTATES; s++) begin
      pm_norm[s]  = acs_pm[s] - min_pm;
      surv_new[s] = {surv_q[{s[0], acs_sel[s]}][D-2:0], s[1]};
    end
  end

  // Metric, survivor, fill-counter and output registers; all hold when idle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the survivor bank is a small register array, not a RAM, so it
      // takes the async reset; decoding restarts from a known all-zero history.
      for (int s = 0; s < NSTATES; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
        surv_q[s] <= '0;
      end
      fill_q  <= '0;
      valid_o <= 1'b0;
      d_out   <= 1'b0;
    end else if (enable_i) begin
      for (int s = 0; s < NSTATES; s++) begin
        pm_q[s]   <= pm_norm[s];
        surv_q[s] <= surv_new[s];
      end
      if (fill_q < CW'(D)) fill_q <= fill_q + CW'(1);
      valid_o <= (fill_q >= CW'(D - 1));
      d_out   <= surv_new[best][D-1];
    end else begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed and random bench for viterbi_decoder: error-free, single error,
// enable gaps, mid-stream reset and a long noisy stream against a reference model.
module tb_viterbi_decoder;

  localparam int D     = 16;
  localparam int MAXN  = 600;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i;
  logic [1:0] d_in;
  logic       valid_o;
  logic       d_out;

  int checks = 0;
  int errors = 0;

  // Stream buffers shared by the stimulus tasks.
  bit         src [MAXN];
  logic [1:0] err [MAXN];
  int         n_src;
  int         first_valid;

  // Reference model state.
  int          m_pm   [4];
  logic [D-1:0] m_surv [4];
  int          m_fill;
  logic        m_valid;
  logic        m_dout;

  viterbi_decoder #(.D(D), .MW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable_i),
    .d_in     (d_in),
    .valid_o  (valid_o),
    .d_out    (d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_pm[s]   = (s == 0) ? 0 : 32;
      m_surv[s] = '0;
    end
    m_fill  = 0;
    m_valid = 1'b0;
    m_dout  = 1'b0;
  endtask

  // Forward enumeration over (previous state, input bit); scanning previous
  // states in ascending order with a strict compare keeps the r0=0 predecessor.
  task automatic model_step(input logic en, input logic [1:0] sym);
    int           best_c [4];
    logic [D-1:0] best_s [4];
    bit           seen   [4];
    int           mn;
    int           bi;
    if (!en) begin
      m_valid = 1'b0;
      return;
    end
    for (int s = 0; s < 4; s++) seen[s] = 1'b0;
    for (int ps = 0; ps < 4; ps++) begin
      for (int b = 0; b < 2; b++) begin
        int r1, r0, e1, e0, bm, c, ns;
        r1 = (ps >> 1) & 1;
        r0 = ps & 1;
        e1 = b ^ r1 ^ r0;
        e0 = b ^ r0;
        bm = ((int'(sym[1]) != e1) ? 1 : 0) + ((int'(sym[0]) != e0) ? 1 : 0);
        c  = m_pm[ps] + bm;
        if (c > 255) c = 255;
        ns = b * 2 + r1;
        if (!seen[ns] || c < best_c[ns]) begin
          seen[ns]   = 1'b1;
          best_c[ns] = c;
          best_s[ns] = {m_surv[ps][D-2:0], b[0]};
        end
      end
    end
    mn = best_c[0];
    bi = 0;
    for (int s = 1; s < 4; s++) begin
      if (best_c[s] < mn) begin
        mn = best_c[s];
        bi = s;
      end
    end
    m_dout  = best_s[bi][D-1];
    m_valid = (m_fill >= D - 1);
    if (m_fill < D) m_fill++;
    for (int s = 0; s < 4; s++) begin
      m_pm[s]   = best_c[s] - mn;
      m_surv[s] = best_s[s];
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic en, input logic [1:0] sym, input string tag);
    @(negedge clk);
    enable_i = en;
    d_in     = sym;
    model_step(en, sym);
    @(posedge clk);
    #1;
    check($sformatf("%s model valid", tag), valid_o, m_valid);
    check($sformatf("%s model dout", tag), d_out, m_dout);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("%s pm%0d", tag, s), dut.pm_q[s], m_pm[s]);
      check($sformatf("%s pm%0d below max", tag, s), dut.pm_q[s] == 8'hFF, 0);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst      = 1'b0;
    enable_i = 1'b0;
    d_in     = 2'b00;
    model_reset();
    #1;
    check($sformatf("%s valid", tag), valid_o, 0);
    check($sformatf("%s dout", tag), d_out, 0);
    check($sformatf("%s pm0", tag), dut.pm_q[0], 0);
    check($sformatf("%s pm3", tag), dut.pm_q[3], 32);
    check($sformatf("%s surv2", tag), dut.surv_q[2], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Encode src[0..n_src-1], apply err[] masks, optionally insert 3-cycle gaps
  // after every 2nd symbol, and check decoded bits against the source.
  task automatic send_stream(input string tag, input bit gaps);
    logic       r1, r0, b;
    logic [1:0] sym;
    int         n_en;
    r1 = 1'b0;
    r0 = 1'b0;
    n_en = 0;
    first_valid = -1;
    for (int i = 0; i < n_src; i++) begin
      b   = src[i];
      sym = {b ^ r1 ^ r0, b ^ r0} ^ err[i];
      r0  = r1;
      r1  = b;
      step(1'b1, sym, tag);
      n_en++;
      if (valid_o === 1'b1 && first_valid < 0) first_valid = n_en;
      if (n_en >= D) begin
        check($sformatf("%s valid sym%0d", tag, n_en), valid_o, 1);
        check($sformatf("%s bit%0d", tag, n_en - D), d_out, src[n_en - D]);
      end else begin
        check($sformatf("%s no valid sym%0d", tag, n_en), valid_o, 0);
      end
      if (gaps && (i % 2 == 1)) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 2'($urandom_range(0, 3)), $sformatf("%s gap", tag));
          check($sformatf("%s gap valid", tag), valid_o, 0);
          if (n_en >= D)
            check($sformatf("%s gap hold", tag), d_out, src[n_en - D]);
        end
      end
    end
  endtask

  task automatic load_base();
    bit base [10];
    base = '{1, 0, 0, 0, 1, 0, 0, 1, 1, 0};
    n_src = 30;
    for (int i = 0; i < MAXN; i++) begin
      src[i] = (i < 10) ? base[i] : 1'b0;
      err[i] = 2'b00;
    end
  endtask

  initial begin
    rst      = 1'b0;
    enable_i = 1'b0;
    d_in     = 2'b00;

    // Power-up reset.
    do_reset("reset");

    // Error-free stream; first valid after the 16th symbol.
    load_base();
    send_stream("clean", 1'b0);
    check("clean first valid", first_valid, 16);

    // Single error on bit 1 of the 5th symbol.
    do_reset("reset_b");
    load_base();
    err[4] = 2'b10;
    send_stream("single_err", 1'b0);

    // Enable gaps of 3 idle cycles after every 2nd symbol.
    do_reset("reset_c");
    load_base();
    send_stream("gaps", 1'b1);

    // Reset after symbol 8, then resend the full stream.
    do_reset("reset_d");
    load_base();
    n_src = 8;
    send_stream("pre_reset", 1'b0);
    do_reset("mid_reset");
    load_base();
    send_stream("after_reset", 1'b0);
    check("after_reset first valid", first_valid, 16);

    // Long random stream, one bit error per 8 symbols.
    do_reset("reset_e");
    n_src = 500;
    for (int i = 0; i < MAXN; i++) begin
      src[i] = (i < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
      err[i] = (i % 8 == 7) ? 2'($urandom_range(1, 2)) : 2'b00;
    end
    send_stream("random", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk       input   1  single clock; all state updates on rising edge
  rst       input   1  asynchronous, active-low reset
  enable_i  input   1  d_in holds a valid received symbol this cycle
  d_in      input   2  received hard-decision symbol {g0 bit, g1 bit}
  valid_o   output  1  d_out holds a decoded bit this cycle
  d_out     output  1  decoded data bit
REQ-002 The block SHALL have these parameters, one per line: name, default, meaning.
  D   16  survivor depth and decode latency, in symbols
  MW  8   path-metric width, in bits

Function
REQ-003 The block SHALL decode the rate-1/2, K=3 code used by the team's encoder.
  - Encoder shift register {r1,r0}; r1 is the previous input bit.
  - For input b: d_in[1] = b^r1^r0 (G0=111) and d_in[0] = b^r0 (G1=101).
  - Next state {b,r1}.
  - The encoder starts in state 00.
REQ-004 Trellis: 4 states; state index = {r1,r0}; next state ns={b,r1} has predecessors {r1,0} and {r1,1}.
REQ-005 Branch metric SHALL be the Hamming distance, 0..2, between d_in and the expected branch symbol.
REQ-006 Add-compare-select, per next state: candidate = PM[pred] + BM, with saturating add to 2^MW-1.
  - Select the smaller candidate.
  - On a tie, select the predecessor with r0=0.
REQ-007 Normalisation: after ACS, subtract the minimum of the 4 new metrics from all 4 before storing, so at least one stored metric is 0 each update.
REQ-008 Survivor memory SHALL be register exchange: new survivor[ns] = {survivor[selected pred][D-2:0], b}, where b = ns[1].
REQ-009 Enable gating:
  - ACS, metric and survivor updates SHALL occur only in cycles with enable_i=1.
  - With enable_i=0, all metrics, survivors and counters hold, and d_out holds.
REQ-010 Fill counter:
  - Counts enabled symbols and saturates at D.
  - On an enabled cycle, valid_o SHALL be registered as 1 when the pre-update count is at least D-1; otherwise valid_o is registered as 0.
REQ-011 Output selection:
  - On an enabled cycle, d_out SHALL be registered as bit D-1 of the updated survivor of the state with minimum updated metric.
  - On a tie, select the lowest state index.
REQ-012 Latency: the decoded bit for the k-th enabled symbol (k from 1) SHALL appear with valid_o=1 in the cycle after the (k+D-1)-th enabled symbol.
REQ-013 A symbol stream containing no errors SHALL decode exactly to the encoder input.
REQ-014 No flush or tail handling: the last D-1 bits are emitted only if further symbols are supplied.

Reset
REQ-015 On rst=0, asynchronously:
  - PM[0]=0 and PM[1..3]=32.
  - All survivors=0 and fill counter=0.
  - valid_o=0 and d_out=0.
REQ-016 Reset asserted mid-stream SHALL discard all history; after release, decoding restarts as from power-up, and the first valid_o occurs D enabled symbols later.

Structure
REQ-017 Package viterbi_pkg SHALL hold:
  - constants K=3, NSTATES=4 and the generators G0=3'b111, G1=3'b101;
  - the state-index typedef;
  - a function returning the expected branch symbol for (state, b).
REQ-018 One sub-module, viterbi_acs, SHALL implement REQ-006 for one next state; the top instantiates it 4 times. Normalisation, survivors and output selection stay in the top.

Verification
REQ-019 Error-free stream: encode 1,0,0,0,1,0,0,1,1,0 followed by 20 zeros (the first four symbols are 11,10,11,00), all with enable_i=1.
  -> valid_o first rises 16 cycles after the first symbol.
  -> d_out reproduces 1,0,0,0,1,0,0,1,1,0,0,...
REQ-020 Single error: same stream with the 5th symbol's bit 1 flipped -> identical d_out sequence.
REQ-021 Enable gaps: same stream with enable_i=0 for 3 cycles inserted after every 2nd symbol.
  -> Identical d_out sequence.
  -> valid_o=0 and d_out held during every gap.
REQ-022 Reset mid-stream: drive rst=0 after symbol 8, release it, then resend the full stream.
  -> valid_o=0 for the first 15 enabled symbols after release, then the correct sequence.
REQ-023 Long random stream: 500 random bits, with one bit error injected per 8 symbols.
  -> Every d_out matches the input, compared against a bit-accurate reference model that includes the tie rules.
  -> Stored metrics never reach 2^MW-1.
REQ-024 Bench SHALL tally good/bad comparisons and report both counts at the end.
